melody_sequencer: RTL

Plays a stored score through the note-period ROM to produce a square-wave tone for the board speaker or buzzer pin. A small internal score RAM holds entries of {note index, duration}; the sequencer fetches each entry, looks up its half-rate period in the external period ROM, generates the tone for the programmed duration and advances. It sits between the bus/register front end that writes the score and the period ROM plus audio output pin.

---
 rtl/melody_sequencer_if.sv | 14 +
 rtl/melody_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer_if.sv
// Score-write bus and period-ROM port of melody_sequencer.
// master: register front end plus ROM; slave: the sequencer.
interface melody_sequencer_if #(
  parameter int SCORE_AW = 5
);
  logic                wr_en;
  logic [SCORE_AW-1:0] wr_addr;
  logic [15:0]         wr_data;
  logic [3:0]          rom_addr;
  logic [31:0]         rom_data;

  modport master (output wr_en, wr_addr, wr_data, rom_data, input rom_addr);
  modport slave  (input wr_en, wr_addr, wr_data, rom_data, output rom_addr);
endinterface

// File: rtl/melody_sequencer.sv
// Plays {note, duration} score entries as a square-wave tone via the period ROM.
// Define MELODY_GAP_EN to insert GAP_TICKS of silence between consecutive notes.
module melody_sequencer #(
  parameter int SCORE_AW  = 5,
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  melody_sequencer_if.slave   bus,
  output logic                tone_out,
  output logic                busy,
  output logic                done,
  output logic [SCORE_AW-1:0] cur_addr
);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int GAP_W  = $clog2(GAP_TICKS + 1);
  // The tick counter is shared by note durations (12 bits) and the gap.
  localparam int CNT_W  = (GAP_W > 12) ? GAP_W : 12;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_PLAY
`ifdef MELODY_GAP_EN
    , S_GAP
`endif
  } state_e;

  logic [15:0] score_mem [2**SCORE_AW];

  // NOTE: storage arrays carry no reset; only the control state below needs one.
  always_ff @(posedge clk) begin
    if (bus.wr_en) score_mem[bus.wr_addr] <= bus.wr_data;
  end

  state_e              state_q, state_d;
  logic [SCORE_AW-1:0] cur_addr_q, cur_addr_d;
  logic [3:0]          note_q, note_d;
  logic [11:0]         dur_q, dur_d;
  logic [31:0]         period_q, period_d;
  logic                rest_q, rest_d;
  logic [31:0]         phase_q, phase_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tone_q, tone_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic        tick_wrap;
  logic [31:0] phase_nxt;
  logic        score_end;
  logic        advance;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    note_d     = note_q;
    dur_d      = dur_q;
    period_d   = period_q;
    rest_d     = rest_q;
    phase_d    = phase_q;
    tick_d     = tick_q;
    cnt_d      = cnt_q;
    tone_d     = 1'b0;
    done_d     = 1'b0;
    score_end  = 1'b0;
    advance    = 1'b0;
    tick_wrap  = (tick_q == TICK_W'(TICK_DIV - 1));
    phase_nxt  = (phase_q == period_q - 32'd1) ? 32'd0 : phase_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d    = S_FETCH;
          cur_addr_d = '0;
        end
      end
      S_FETCH: begin
        note_d  = score_mem[cur_addr_q][15:12];
        dur_d   = score_mem[cur_addr_q][11:0];
        state_d = S_LOAD;
      end
      S_LOAD: begin
        period_d = bus.rom_data;
        rest_d   = (note_q == 4'd0) || (bus.rom_data < 32'd2);
        phase_d  = '0;
        tick_d   = '0;
        cnt_d    = '0;
        if (dur_q == 12'd0) begin
          score_end = 1'b1;
        end else begin
          state_d = S_PLAY;
          tone_d  = !rest_d;
        end
      end
      S_PLAY: begin
        tick_d  = tick_wrap ? '0 : tick_q + TICK_W'(1);
        cnt_d   = tick_wrap ? cnt_q + CNT_W'(1) : cnt_q;
        phase_d = phase_nxt;
        // Registered tone precomputes the phase of the following cycle.
        tone_d  = !rest_q && (phase_nxt < (period_q >> 1));
        if (tick_wrap && (cnt_q == CNT_W'(dur_q - 12'd1))) begin
          tone_d = 1'b0;
          if (cur_addr_q == '1) begin
            score_end = 1'b1;
          end else begin
`ifdef MELODY_GAP_EN
            state_d = S_GAP;
            tick_d  = '0;
            cnt_d   = '0;
`else
            advance = 1'b1;
`endif
          end
        end
      end
`ifdef MELODY_GAP_EN
      S_GAP: begin
        tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
        cnt_d  = tick_wrap ? cnt_q + CNT_W'(1) : cnt_q;
        if (tick_wrap && (cnt_q == CNT_W'(GAP_TICKS - 1))) advance = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      cur_addr_d = cur_addr_q + SCORE_AW'(1);
      state_d    = S_FETCH;
    end
    if (score_end) begin
      if (loop_en) begin
        cur_addr_d = '0;
        state_d    = S_FETCH;
      end else begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end
    // Stop wins over everything, including a same-cycle natural end.
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      tone_d  = 1'b0;
      done_d  = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      note_q     <= '0;
      dur_q      <= '0;
      period_q   <= '0;
      rest_q     <= 1'b1;
      phase_q    <= '0;
      tick_q     <= '0;
      cnt_q      <= '0;
      tone_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      period_q   <= period_d;
      rest_q     <= rest_d;
      phase_q    <= phase_d;
      tick_q     <= tick_d;
      cnt_q      <= cnt_d;
      tone_q     <= tone_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.rom_addr = note_q;
  assign tone_out     = tone_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cur_addr     = cur_addr_q;
endmodule
